dmvm_scheduler: RTL



---
 rtl/dmvm_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmvm_scheduler.sv
// Issue sequencer for the attention-coefficient datapath: per-node WH reads, credit throttling, delay-matched tags.
// Optional stall performance counter built only when DMVM_SCHED_PERF_EN is defined.
module dmvm_scheduler #(
    parameter int NODE_CNT_W      = 8,
    parameter int ADDR_W          = 10,
    parameter int WH_DEPTH        = 1024,
    parameter int PIPE_LAT        = 6,
    parameter int COEF_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sg_valid_i,
    output logic                  sg_ready_o,
    input  logic [NODE_CNT_W-1:0] sg_num_nodes_i,
    output logic                  wh_rd_en_o,
    output logic [ADDR_W-1:0]     wh_addr_o,
    output logic                  dmvm_valid_o,
    input  logic                  coef_pop_i,
    output logic                  tag_valid_o,
    output logic                  tag_src_o,
    output logic                  tag_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int CRED_W  = $clog2(COEF_FIFO_DEPTH + 1);
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NODE_CNT_W-1:0] node_rem_q;
    logic                  first_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [CRED_W-1:0]     credits_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic [PIPE_LAT-1:0]   tv_q, ts_q, tl_q;
    logic                  done_q, err_q;
    logic                  accept, issue, drain_end;

    // Descriptor handshake: a transfer happens on any cycle where sg_valid_i and sg_ready_o
    // are both high; sg_ready_o depends only on state, never on sg_valid_i.
    always_comb begin
        accept    = sg_valid_i && (state_q == IDLE);
        issue     = (state_q == ISSUE) && (credits_q != '0);
        drain_end = (state_q == DRAIN) && (drain_q <= DRAIN_W'(1));
        state_d   = state_q;
        case (state_q)
            IDLE:    if (accept && (sg_num_nodes_i != '0)) state_d = ISSUE;
            ISSUE:   if (issue && (node_rem_q == NODE_CNT_W'(1))) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // done_o is registered, so DRAIN is left one count early and the pulse coincides with
    // the return to IDLE (sg_ready_o high, busy_o low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_rem_q <= '0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= drain_end;
            err_q  <= accept && (sg_num_nodes_i == '0);
            if (accept && (sg_num_nodes_i != '0)) begin
                node_rem_q <= sg_num_nodes_i;
                first_q    <= 1'b1;
            end
            if (issue) begin
                addr_q     <= (addr_q == ADDR_W'(WH_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                node_rem_q <= node_rem_q - NODE_CNT_W'(1);
                first_q    <= 1'b0;
                if (node_rem_q == NODE_CNT_W'(1)) drain_q <= DRAIN_W'(PIPE_LAT);
            end
            if ((state_q == DRAIN) && (drain_q != '0)) drain_q <= drain_q - DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CRED_W'(COEF_FIFO_DEPTH);
        end else begin
            case ({issue, coef_pop_i})
                2'b10:   credits_q <= credits_q - CRED_W'(1);
                2'b01:   if (credits_q != CRED_W'(COEF_FIFO_DEPTH)) credits_q <= credits_q + CRED_W'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            ts_q <= '0;
            tl_q <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tv_q[i] <= tv_q[i-1];
                ts_q[i] <= ts_q[i-1];
                tl_q[i] <= tl_q[i-1];
            end
            tv_q[0] <= issue;
            ts_q[0] <= issue && first_q;
            tl_q[0] <= issue && (node_rem_q == NODE_CNT_W'(1));
        end
    end

`ifdef DMVM_SCHED_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else if ((state_q == ISSUE) && (credits_q == '0) && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign sg_ready_o   = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign dmvm_valid_o = issue;
    assign wh_rd_en_o   = issue;
    assign wh_addr_o    = issue ? addr_q : '0;
    assign tag_valid_o  = tv_q[PIPE_LAT-1];
    assign tag_src_o    = ts_q[PIPE_LAT-1];
    assign tag_last_o   = tl_q[PIPE_LAT-1];
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
